// File: rtl/scalar_reg_bank_pkg.sv
// Shared types and constants for the scalar register bank of the vector ASIP.
// Register 0 is hardwired to zero and addresses 16..31 are unimplemented.
package asip_scalar_pkg;

    localparam int NUM_SREGS = 16;
    localparam int SADDR_W   = 5;
    localparam int SIDX_W    = 4;

    typedef logic [SADDR_W-1:0] sreg_addr_t;
    typedef logic [SIDX_W-1:0]  sreg_idx_t;

    // True only for implemented, writable registers (1..15).
    function automatic logic is_sreg(sreg_addr_t addr);
        return (addr != '0) && (addr < SADDR_W'(NUM_SREGS));
    endfunction

    function automatic sreg_idx_t sreg_idx(sreg_addr_t addr);
        return addr[SIDX_W-1:0];
    endfunction

endpackage

// File: rtl/scalar_reg_bank_if.sv
// Decode/write-back side of the scalar register bank: write-back, issue-time
// reservation, hazard check addresses, and the resulting stall/busy flags.
interface scalar_reg_bank_if #(
    parameter int N = 32
);
    import asip_scalar_pkg::*;

    logic                 we;
    sreg_addr_t           wa;
    logic [N-1:0]         wd;
    logic                 rsv_en;
    sreg_addr_t           rsv_addr;
    sreg_addr_t           chk_a;
    sreg_addr_t           chk_b;
    logic                 stall;
    logic [NUM_SREGS-1:0] busy;

    modport master (
        output we, wa, wd, rsv_en, rsv_addr, chk_a, chk_b,
        input  stall, busy
    );

    modport slave (
        input  we, wa, wd, rsv_en, rsv_addr, chk_a, chk_b,
        output stall, busy
    );

endinterface

// File: rtl/scalar_reg_bank_scoreboard.sv
// Outstanding-write scoreboard: one busy bit per scalar register, set at issue
// and cleared at write-back, plus the RAW/WAW stall to decode.
module scalar_scoreboard
    import asip_scalar_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  sreg_addr_t           wa,
    input  logic                 rsv_en,
    input  sreg_addr_t           rsv_addr,
    input  sreg_addr_t           chk_a,
    input  sreg_addr_t           chk_b,
    output logic                 stall,
    output logic [NUM_SREGS-1:0] busy
);

    logic [NUM_SREGS-1:0] busy_q;
    logic [NUM_SREGS-1:0] busy_d;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        busy_d = busy_q;
        if (we && is_sreg(wa)) begin
            busy_d[sreg_idx(wa)] = 1'b0;
        end
        // Applied after the clear so a same-address reserve wins.
        if (rsv_en && is_sreg(rsv_addr)) begin
            busy_d[sreg_idx(rsv_addr)] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // No write-back bypass: stall sees only the registered busy bits.
    always_comb begin
        stall = 1'b0;
        if (is_sreg(chk_a) && busy_q[sreg_idx(chk_a)]) begin
            stall = 1'b1;
        end
        if (is_sreg(chk_b) && busy_q[sreg_idx(chk_b)]) begin
            stall = 1'b1;
        end
        if (rsv_en && is_sreg(rsv_addr) && busy_q[sreg_idx(rsv_addr)]) begin
            stall = 1'b1;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/scalar_reg_bank.sv
// Sixteen N-bit scalar registers presented in parallel as R00..R15, with the
// outstanding-write scoreboard instantiated alongside.
module scalar_reg_bank
    import asip_scalar_pkg::*;
#(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              rst,
    scalar_reg_bank_if.slave  bus,
    output logic [N-1:0]      R00,
    output logic [N-1:0]      R01,
    output logic [N-1:0]      R02,
    output logic [N-1:0]      R03,
    output logic [N-1:0]      R04,
    output logic [N-1:0]      R05,
    output logic [N-1:0]      R06,
    output logic [N-1:0]      R07,
    output logic [N-1:0]      R08,
    output logic [N-1:0]      R09,
    output logic [N-1:0]      R10,
    output logic [N-1:0]      R11,
    output logic [N-1:0]      R12,
    output logic [N-1:0]      R13,
    output logic [N-1:0]      R14,
    output logic [N-1:0]      R15
);

    logic [N-1:0] regs_q [NUM_SREGS];
    logic [N-1:0] regs_d [NUM_SREGS];

    always_comb begin
        regs_d = regs_q;
        if (bus.we && is_sreg(bus.wa)) begin
            regs_d[sreg_idx(bus.wa)] = bus.wd;
        end
        regs_d[0] = '0;
    end

    // NOTE: the register array is reset because downstream muxes read every entry from the first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    scalar_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .we       (bus.we),
        .wa       (bus.wa),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .chk_a    (bus.chk_a),
        .chk_b    (bus.chk_b),
        .stall    (bus.stall),
        .busy     (bus.busy)
    );

    assign R00 = regs_q[0];
    assign R01 = regs_q[1];
    assign R02 = regs_q[2];
    assign R03 = regs_q[3];
    assign R04 = regs_q[4];
    assign R05 = regs_q[5];
    assign R06 = regs_q[6];
    assign R07 = regs_q[7];
    assign R08 = regs_q[8];
    assign R09 = regs_q[9];
    assign R10 = regs_q[10];
    assign R11 = regs_q[11];
    assign R12 = regs_q[12];
    assign R13 = regs_q[13];
    assign R14 = regs_q[14];
    assign R15 = regs_q[15];

endmodule

// File: doc/scalar_reg_bank.md
# scalar_reg_bank

Scalar register bank of the vector ASIP. It holds sixteen N-bit scalar registers and presents them in parallel as R00..R15, which feed the data inputs of the downstream 16-way scalar operand mux. It also tracks, per register, whether a write-back is still outstanding, and raises a stall for the decode stage on read-after-write and write-after-write hazards.

## Interface
Parameters:
- N, 32, data width of each scalar register.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- rst  input  1  Reset, synchronous and active-high.
- we  input  1  Write-back enable.
- wa  input  5  Write-back address.
- wd  input  N  Write-back data.
- rsv_en  input  1  Issue-time reservation of a destination register.
- rsv_addr  input  5  Destination register being reserved.
- chk_a, chk_b  input  5 each  Source addresses of the instruction in decode.
- stall  output  1  Combinational hazard flag to decode.
- busy  output  16  Registered outstanding-write flags, bit i for register i.
- R00..R15  output  N each  Registered register contents, to the mux D00..D15 inputs.

## Operation
- Address space is 5 bits and only 0..15 are implemented. Any address 16..31 on wa, rsv_addr, chk_a or chk_b is a no-op and never hazards, consistent with the mux returning 0 for those selects.
- R00 is hardwired to zero:
  - Writes to address 0 are dropped.
  - Reservations of address 0 are dropped.
  - busy[0] is constant 0.
- Write: when we=1 and 1≤wa≤15, reg[wa] ← wd and busy[wa] ← 0 at the clock edge.
- Reserve: when rsv_en=1 and 1≤rsv_addr≤15, busy[rsv_addr] ← 1 at the clock edge.
- Same-edge write and reserve:
  - Same address: the reserve wins, so busy ends at 1 and the data is still written.
  - Different addresses: both take effect.
- stall is the OR of three terms:
  - busy[chk_a], with chk_a in 1..15.
  - busy[chk_b], with chk_b in 1..15.
  - rsv_en & busy[rsv_addr], with rsv_addr in 1..15 (WAW).
- stall uses the current registered busy. A write-back in the same cycle does not clear stall until the next cycle; there is no bypass.
- The bank does not suppress rsv_en while stall=1. Decode must gate it.

## Timing
- Reset: on a clock edge with rst=1, all R00..R15 go to 0 and busy goes to 16'h0000. stall then depends only on inputs and evaluates to 0. Reset overrides any same-cycle we or rsv_en.
- Write latency is 1 cycle: data written at edge k appears on Rxx after edge k and is read through the mux in cycle k+1.
- Reserve latency is 1 cycle: busy and stall reflect a reservation from the cycle after rsv_en.
- Reset mid-operation discards all pending reservations. Write-backs that arrive after reset are still written and clear a busy bit that is already 0.
- Output timing: stall is combinational from chk_a, chk_b, rsv_en, rsv_addr and the busy register. All other outputs are registered.

## Structure
- Package asip_scalar_pkg holds:
  - NUM_SREGS = 16.
  - SADDR_W = 5.
  - typedef sreg_addr_t (logic [SADDR_W-1:0]).
  - Function is_sreg(addr), which returns 1 for addresses 1..15.
- Sub-module scalar_scoreboard holds the busy register, the reserve/clear logic and the stall generation. The top level holds the data registers and instantiates the scoreboard.

## Test plan
- Reset: drive rst for 1 cycle with we=1, wa=3, wd=5 → all Rxx=0, busy=0, stall=0.
- Write: we=1, wa=5, wd=32'hDEADBEEF → R05=DEADBEEF next cycle, all other registers unchanged. Then wa=0, wd=7 → R00 stays 0.
- RAW hazard:
  - rsv_en=1, rsv_addr=7 → busy=16'h0080.
  - Next cycle chk_a=7 → stall=1.
  - we=1, wa=7 → busy=0 and stall=0 the following cycle.
- Same-edge collision: we=1, wa=9 together with rsv_en=1, rsv_addr=9 while busy[9]=1 → R09 updated and busy[9] stays 1.
- Out-of-range: we=1, wa=20 → no register changes. rsv_addr=18 → busy unchanged. chk_a=31 → stall=0.
- WAW hazard: with busy[4]=1, rsv_en=1, rsv_addr=4 → stall=1 in the same cycle.
